// File: rtl/cv_pkg.sv
// Shared definitions for the fetch/decode front end: the canonical NOP
// and the queue entry layout for the default 32-bit PC.
package cv_pkg;

    localparam logic [31:0] NOP_INSTR = 32'h00000013;
    localparam int          CV_XLEN   = 32;

    typedef struct packed {
        logic [CV_XLEN-1:0] pc;
        logic [31:0]        instr;
    } fd_entry_t;

    // Occupancy counter width for a queue of the given depth (0..DEPTH inclusive).
    function automatic int count_width(input int depth);
        return $clog2(depth) + 1;
    endfunction

endpackage

// File: rtl/sync_fifo.sv
// Generic synchronous FIFO: storage array, wrapping read/write pointers and an
// occupancy counter; full/empty come from the counter, not pointer compares.
module sync_fifo
    import cv_pkg::*;
#(
    parameter type T     = fd_entry_t,
    parameter int  DEPTH = 2,
    localparam int PW    = $clog2(DEPTH),
    localparam int CW    = $clog2(DEPTH) + 1
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          clear,
    input  logic          push,
    input  logic          pop,
    input  T              wdata,
    output T              head,
    output logic [CW-1:0] count,
    output logic          full,
    output logic          empty
);

    T              mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic          push_ok;
    logic          pop_ok;

    assign full    = (count == CW'(DEPTH));
    assign empty   = (count == '0);
    assign push_ok = push & ~full & ~clear;
    assign pop_ok  = pop & ~empty & ~clear;
    assign head    = mem[rd_ptr];

    // Clear wins over push and pop so a redirect leaves a clean, empty queue.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else if (clear) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push_ok) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop_ok) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            count <= count + CW'(push_ok) - CW'(pop_ok);
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem[wr_ptr] <= wdata;
        end
    end

endmodule

// File: rtl/fd_queue.sv
// Fetch-to-decode instruction queue with flush and NOP substitution.
// Define FD_QUEUE_BYPASS_EN for a zero-latency path through an empty queue.
module fd_queue
    import cv_pkg::*;
#(
    parameter int DEPTH = 2,
    parameter int XLEN  = 32
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   valid_F,
    input  logic [XLEN-1:0]        pc_F,
    input  logic [31:0]            instr_F,
    output logic                   ready_F,
    input  logic                   stall_D,
    input  logic                   flush,
    output logic                   valid_D,
    output logic [XLEN-1:0]        pc_D,
    output logic [31:0]            instr_D,
    output logic [$clog2(DEPTH):0] count
);

    typedef struct packed {
        logic [XLEN-1:0] pc;
        logic [31:0]     instr;
    } entry_t;

    entry_t          wr_entry;
    entry_t          head;
    logic            fifo_push;
    logic            fifo_pop;
    logic            fifo_full;
    logic            fifo_empty;
    logic            bypass_hit;
    logic            bypass_take;
    logic [XLEN-1:0] last_pc;

    assign wr_entry = '{pc: pc_F, instr: instr_F};
    assign ready_F  = ~fifo_full;

`ifdef FD_QUEUE_BYPASS_EN
    // An unstalled decode swallows the fetch word directly when nothing is queued.
    assign bypass_hit  = fifo_empty & valid_F & ~flush;
    assign bypass_take = bypass_hit & ~stall_D;
`else
    assign bypass_hit  = 1'b0;
    assign bypass_take = 1'b0;
`endif

    always_comb begin
        fifo_push = valid_F & ready_F & ~flush & ~bypass_take;
        fifo_pop  = ~fifo_empty & ~stall_D & ~flush;
        valid_D   = ~fifo_empty | bypass_hit;
        pc_D      = last_pc;
        instr_D   = NOP_INSTR;
        if (!fifo_empty) begin
            pc_D    = head.pc;
            instr_D = head.instr;
        end else if (bypass_hit) begin
            pc_D    = pc_F;
            instr_D = instr_F;
        end
    end

    // Remembers the last presented PC so pc_D holds steady while empty.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last_pc <= '0;
        end else if (valid_D) begin
            last_pc <= pc_D;
        end
    end

    sync_fifo #(
        .T     (entry_t),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .clear (flush),
        .push  (fifo_push),
        .pop   (fifo_pop),
        .wdata (wr_entry),
        .head  (head),
        .count (count),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

endmodule

// File: tb/tb_fd_queue.sv
// Self-checking bench for fd_queue: queue-based reference model checked every
// cycle, directed scenarios with literal expectations, and a randomized stream.
module tb_fd_queue;
    import cv_pkg::*;

    localparam int DEPTH = 2;
    localparam int XLEN  = 32;
`ifdef FD_QUEUE_BYPASS_EN
    localparam bit BYP = 1'b1;
`else
    localparam bit BYP = 1'b0;
`endif

    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
    } ent_t;

    logic        clk;
    logic        reset;
    logic        valid_F;
    logic [31:0] pc_F;
    logic [31:0] instr_F;
    logic        ready_F;
    logic        stall_D;
    logic        flush;
    logic        valid_D;
    logic [31:0] pc_D;
    logic [31:0] instr_D;
    logic [1:0]  count;

    int n_compared   = 0;
    int n_mismatched = 0;

    ent_t        mq[$];
    logic [31:0] consumed[$];
    logic [31:0] m_last_pc;
    logic        exp_valid;
    logic [31:0] exp_pc;
    logic [31:0] exp_instr;
    ent_t        popped;
    int          sz;
    bit          take;
    bit          mpush;
    bit          mpop;

    fd_queue #(.DEPTH(DEPTH), .XLEN(XLEN)) dut (
        .clk     (clk),
        .reset   (reset),
        .valid_F (valid_F),
        .pc_F    (pc_F),
        .instr_F (instr_F),
        .ready_F (ready_F),
        .stall_D (stall_D),
        .flush   (flush),
        .valid_D (valid_D),
        .pc_D    (pc_D),
        .instr_D (instr_D),
        .count   (count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [31:0] instrFor(input logic [31:0] pc);
        return (pc * 32'h9E3779B1) ^ 32'h5A5A0000;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        n_compared++;
        if (actual !== expected) begin
            n_mismatched++;
            $display("[TB] FAIL %s: got %h, expected %h at %0t", name, actual, expected, $time);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [31:0] pc, input logic s, input logic f);
        @(posedge clk);
        #1;
        valid_F = v;
        pc_F    = pc;
        instr_F = instrFor(pc);
        stall_D = s;
        flush   = f;
    endtask

    // What decode must see right now, from the queue contents and live inputs.
    task automatic modelExpect();
        if (mq.size() > 0) begin
            exp_valid = 1'b1;
            exp_pc    = mq[0].pc;
            exp_instr = mq[0].instr;
        end else if (BYP && valid_F && !flush) begin
            exp_valid = 1'b1;
            exp_pc    = pc_F;
            exp_instr = instr_F;
        end else begin
            exp_valid = 1'b0;
            exp_pc    = m_last_pc;
            exp_instr = NOP_INSTR;
        end
    endtask

    always @(posedge clk) begin
        if (!reset) begin
            modelExpect();
            if (exp_valid) m_last_pc = exp_pc;
            if (flush) begin
                mq.delete();
            end else begin
                sz    = mq.size();
                take  = BYP && sz == 0 && valid_F && !stall_D;
                mpush = valid_F && sz < DEPTH && !take;
                mpop  = sz > 0 && !stall_D;
                if (take) consumed.push_back(pc_F);
                if (mpop) begin
                    popped = mq.pop_front();
                    consumed.push_back(popped.pc);
                end
                if (mpush) mq.push_back('{pc_F, instr_F});
            end
        end
    end

    initial begin
        forever begin
            @(negedge clk);
            if (reset) begin
                mq.delete();
                m_last_pc = '0;
            end
            modelExpect();
            checkOutput("valid_D", 32'(valid_D), 32'(exp_valid));
            checkOutput("pc_D", pc_D, exp_pc);
            checkOutput("instr_D", instr_D, exp_instr);
            checkOutput("count", 32'(count), 32'(mq.size()));
            checkOutput("ready_F", 32'(ready_F), 32'(mq.size() < DEPTH));
        end
    end

    initial begin
        #100000;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        int k;
        int cyc;
        reset   = 1'b1;
        valid_F = 1'b0;
        pc_F    = '0;
        instr_F = '0;
        stall_D = 1'b0;
        flush   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checkOutput("init_instr", instr_D, 32'h00000013);
        checkOutput("init_ready", 32'(ready_F), 32'd1);
        reset = 1'b0;

        // Stall absorbs two pushes, then release pops them in order.
        applyStimulus(1, 32'h100, 1, 0);
        applyStimulus(1, 32'h104, 1, 0);
        applyStimulus(0, 32'h0, 1, 0);
        #1;
        checkOutput("stall_count", 32'(count), 32'd2);
        checkOutput("stall_ready", 32'(ready_F), 32'd0);
        checkOutput("stall_head", pc_D, 32'h100);
        applyStimulus(0, 32'h0, 1, 0);
        applyStimulus(0, 32'h0, 0, 0);
        #1;
        checkOutput("rel_head0", pc_D, 32'h100);
        applyStimulus(0, 32'h0, 0, 0);
        #1;
        checkOutput("rel_head1", pc_D, 32'h104);
        applyStimulus(0, 32'h0, 0, 0);
        #1;
        checkOutput("rel_empty", 32'(valid_D), 32'd0);

        // Full queue: simultaneous push is refused, pop frees a slot next cycle.
        applyStimulus(1, 32'h100, 1, 0);
        applyStimulus(1, 32'h104, 1, 0);
        applyStimulus(1, 32'h108, 0, 0);
        #1;
        checkOutput("full_ready", 32'(ready_F), 32'd0);
        checkOutput("full_count", 32'(count), 32'd2);
        applyStimulus(1, 32'h108, 1, 0);
        #1;
        checkOutput("after_pop_ready", 32'(ready_F), 32'd1);
        checkOutput("after_pop_count", 32'(count), 32'd1);
        checkOutput("after_pop_head", pc_D, 32'h104);
        applyStimulus(0, 32'h0, 0, 0);
        #1;
        checkOutput("refill_count", 32'(count), 32'd2);
        applyStimulus(0, 32'h0, 0, 0);
        #1;
        checkOutput("refill_head", pc_D, 32'h108);
        applyStimulus(0, 32'h0, 0, 0);
        #1;
        checkOutput("drain_count", 32'(count), 32'd0);

        // Flush with a concurrent push drops everything.
        applyStimulus(1, 32'h180, 1, 0);
        applyStimulus(1, 32'h184, 1, 0);
        applyStimulus(1, 32'h200, 0, 1);
        #1;
        checkOutput("flush_cycle_valid", 32'(valid_D), 32'd1);
        applyStimulus(0, 32'h0, 0, 0);
        #1;
        checkOutput("flush_count", 32'(count), 32'd0);
        checkOutput("flush_valid", 32'(valid_D), 32'd0);
        checkOutput("flush_instr", instr_D, 32'h00000013);
        checkOutput("flush_pc_hold", pc_D, 32'h180);

        // Asynchronous reset while two entries are queued.
        applyStimulus(1, 32'h400, 1, 0);
        applyStimulus(1, 32'h404, 1, 0);
        @(posedge clk);
        #1;
        valid_F = 1'b0;
        stall_D = 1'b0;
        reset   = 1'b1;
        #1;
        checkOutput("arst_count", 32'(count), 32'd0);
        checkOutput("arst_valid", 32'(valid_D), 32'd0);
        checkOutput("arst_instr", instr_D, 32'h00000013);
        checkOutput("arst_ready", 32'(ready_F), 32'd1);
        checkOutput("arst_pc", pc_D, 32'h0);
        #5;
        reset = 1'b0;

        // Latency from an empty queue.
        applyStimulus(1, 32'h300, 0, 0);
        #1;
`ifdef FD_QUEUE_BYPASS_EN
        checkOutput("byp_valid", 32'(valid_D), 32'd1);
        checkOutput("byp_pc", pc_D, 32'h300);
        checkOutput("byp_count", 32'(count), 32'd0);
`else
        checkOutput("lat_valid0", 32'(valid_D), 32'd0);
`endif
        applyStimulus(0, 32'h0, 0, 0);
        #1;
`ifdef FD_QUEUE_BYPASS_EN
        checkOutput("byp_after_valid", 32'(valid_D), 32'd0);
        checkOutput("byp_after_count", 32'(count), 32'd0);
`else
        checkOutput("lat_valid1", 32'(valid_D), 32'd1);
        checkOutput("lat_pc1", pc_D, 32'h300);
`endif
        applyStimulus(0, 32'h0, 0, 0);

        // Back-to-back stream with random decode stalls.
        consumed.delete();
        k   = 0;
        cyc = 0;
        while (k < 40 && cyc < 400) begin
            applyStimulus(1, 32'h1000 + 32'(4 * k), ($urandom_range(0, 2) == 0), 0);
            if (mq.size() < DEPTH) k++;
            cyc++;
        end
        checkOutput("stream_pushes", 32'(k), 32'd40);
        repeat (6) applyStimulus(0, 32'h0, 0, 0);
        checkOutput("stream_len", 32'(consumed.size()), 32'd40);
        for (int i = 0; i < 40; i++) begin
            if (i < consumed.size())
                checkOutput("stream_order", consumed[i], 32'h1000 + 32'(4 * i));
        end
        checkOutput("stream_end_count", 32'(count), 32'd0);

        @(posedge clk);
        #1;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_compared, n_mismatched);
        $finish;
    end

endmodule
